// File: rtl/instruction_loader_if.sv
// Host-side byte stream, instruction-memory write port and CPU sequencing flags
// of the boot loader, grouped for the loader and its stream source.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_data;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_write_enable, mem_addr, mem_data,
    input  cpu_reset, busy, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_write_enable, mem_addr, mem_data,
    output cpu_reset, busy, done, error
  );
endinterface

// File: rtl/instruction_loader.sv
// Boot-time program loader: length header, payload and XOR checksum over a
// valid/ready byte stream, written as little-endian words into instruction memory.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset, waiting for start; CPU held in reset
// S_LEN   | collecting the 4-byte little-endian payload length
// S_DATA  | collecting payload bytes, writing a word per 4 bytes or at the end
// S_CHECK | waiting for the checksum byte
// S_DONE  | image verified; CPU released
// S_ERROR | oversize length or checksum mismatch; CPU held in reset
module instruction_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input logic clock,
  input logic reset,
  instruction_loader_if.slave bus
);

  localparam logic [31:0] MAX_BYTES = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   count;
  logic [31:0]           length;
  logic [7:0]            checksum;
  logic [31:0]           word_buf;

  logic                  accept;
  logic [1:0]            lane;
  logic [ADDR_WIDTH:0]   count_next;
  logic [31:0]           full_len;
  logic                  last_byte;
  logic [31:0]           filled_word;
  logic [ADDR_WIDTH-1:0] word_base;

  assign accept     = bus.in_valid && bus.in_ready;
  assign lane       = count[1:0];
  assign count_next = count + 1'b1;
  assign full_len   = {bus.in_data, length[23:0]};
  assign last_byte  = (32'(count_next) == length);
  assign word_base  = {count[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    filled_word = word_buf;
    filled_word[{lane, 3'b000} +: 8] = bus.in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      count                <= '0;
      length               <= '0;
      checksum             <= '0;
      word_buf             <= '0;
      bus.in_ready         <= 1'b0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_addr         <= '0;
      bus.mem_data         <= '0;
      bus.cpu_reset        <= 1'b1;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.error            <= 1'b0;
    end else begin
      bus.mem_write_enable <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state         <= S_LEN;
            count         <= '0;
            length        <= '0;
            checksum      <= '0;
            word_buf      <= '0;
            bus.in_ready  <= 1'b1;
            bus.cpu_reset <= 1'b1;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
          end
        end

        S_LEN: begin
          if (accept) begin
            length[{lane, 3'b000} +: 8] <= bus.in_data;
            count <= count_next;
            if (lane == 2'd3) begin
              count <= '0;
              if (full_len > MAX_BYTES) begin
                state        <= S_ERROR;
                bus.in_ready <= 1'b0;
                bus.busy     <= 1'b0;
                bus.error    <= 1'b1;
              end else if (full_len == 32'd0) begin
                state <= S_CHECK;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            checksum <= checksum ^ bus.in_data;
            count    <= count_next;
            // Buffer restarts from zero so a short final word pads with 0x00.
            if (lane == 2'd3 || last_byte) begin
              bus.mem_write_enable <= 1'b1;
              bus.mem_addr         <= word_base;
              bus.mem_data         <= filled_word;
              word_buf             <= '0;
            end else begin
              word_buf <= filled_word;
            end
            if (last_byte) begin
              state <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
            if (bus.in_data == checksum) begin
              state         <= S_DONE;
              bus.done      <= 1'b1;
              bus.cpu_reset <= 1'b0;
            end else begin
              state     <= S_ERROR;
              bus.error <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
